// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operand, result, opcode, state and command types
package alu_pkg;
  typedef logic [7:0]  operand_t;
  typedef logic [15:0] result_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_PASS = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } issuer_state_t;

  typedef struct packed {
    opcode_t  op;
    operand_t a;
    operand_t b;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);
endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - power-of-two circular command buffer with occupancy count
module alu_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers ALU commands, issues them one at a time, returns responses
// Optional done-timeout is built when ALU_ISSUER_TIMEOUT_EN is defined.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  opcode_t                         cmd_op,
  input  operand_t                        cmd_a,
  input  operand_t                        cmd_b,
  output logic                            alu_start,
  output opcode_t                         alu_opcode,
  output operand_t                        alu_A,
  output operand_t                        alu_B,
  input  result_t                         alu_result,
  input  logic                            alu_done,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output opcode_t                         rsp_op,
  output result_t                         rsp_result,
  output logic                            rsp_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("alu_cmd_issuer: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  issuer_state_t state_q, state_d;
  alu_cmd_t      cmd_in;
  alu_cmd_t      head;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic          capture, timeout;

  assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b};

  alu_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd_valid),
    .push_data(cmd_in),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign alu_start = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);

`ifdef ALU_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;

  // Counts completed ISSUE cycles; the last allowed cycle without done ends the command.
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_ISSUE) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign timeout = (state_q == ST_ISSUE) && !alu_done && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset)        rsp_err <= 1'b0;
    else if (capture) rsp_err <= 1'b0;
    else if (timeout) rsp_err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (alu_done) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (timeout) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alu_opcode <= OP_NOP;
      alu_A      <= '0;
      alu_B      <= '0;
      rsp_op     <= OP_NOP;
      rsp_result <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        alu_opcode <= head.op;
        alu_A      <= head.a;
        alu_B      <= head.b;
      end
      if (capture) begin
        rsp_op     <= alu_opcode;
        rsp_result <= alu_result;
      end else if (timeout) begin
        rsp_op     <= alu_opcode;
        rsp_result <= '0;
      end
    end
  end
endmodule
